imem_program_loader: RTL and testbench

//  Upstream feeder of the cpu top. Accepts a valid/ready stream of 32-bit instruction words,

---
 rtl/loader_pkg.sv | 17 +
 rtl/loader_rd_align.sv | 24 ++
 rtl/imem_program_loader.sv | 156 +++++++++++++++
 tb/tb_imem_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
// The VERIFY state is only reachable when LOADER_VERIFY_EN is defined.
package loader_pkg;

    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 64;
    localparam int COUNT_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/loader_rd_align.sv
// Valid shift register marking the cycle in which rdata_ext answers a read issued RD_LAT cycles earlier.
// Instantiated by imem_program_loader only when LOADER_VERIFY_EN is defined.
module loader_rd_align #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic issue,
    output logic valid
);

    logic [RD_LAT-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | RD_LAT'(issue);
        end
    end

    assign valid = pipe_q[RD_LAT-1];

endmodule

// File: rtl/imem_program_loader.sv
// Streams a program into instruction memory over the cpu external port, then holds cpu enable.
// Defining LOADER_VERIFY_EN adds a read-back checksum pass (VERIFY) before the cpu is enabled.
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int                IMEM_DEPTH = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RD_LAT     = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_last,
    output logic [ADDR_W-1:0]  addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [WORD_W-1:0]  wdata_ext,
    input  logic [WORD_W-1:0]  rdata_ext,
    output logic               cpu_enable,
    output logic [COUNT_W-1:0] word_count,
    output logic               load_error
);

`ifdef LOADER_VERIFY_EN
    localparam state_t AFTER_LAST = ST_VERIFY;
`else
    localparam state_t AFTER_LAST = ST_RUN;
`endif

    state_t             state, next_state;
    logic [COUNT_W-1:0] count_q;
    logic               error_q;
    logic               enable_q;
    logic               handshake;
    logic               full;
    logic               enter_load;

    // halt takes priority over an offered word, so a halted load never writes
    assign s_ready    = (state == ST_LOAD) && !halt;
    assign handshake  = s_valid && s_ready;
    assign full       = (count_q == COUNT_W'(IMEM_DEPTH));
    assign enter_load = (next_state == ST_LOAD) && (state != ST_LOAD);

`ifdef LOADER_VERIFY_EN
    logic [COUNT_W-1:0] issue_q;
    logic [COUNT_W-1:0] rtn_q;
    logic [WORD_W-1:0]  checksum_q;
    logic [WORD_W-1:0]  rd_sum_q;
    logic               rd_valid;
    logic               last_rtn;
    logic               sum_ok;

    loader_rd_align #(.RD_LAT(RD_LAT)) u_rd_align (
        .clk   (clk),
        .arst_n(arst_n),
        .issue (ren_ext),
        .valid (rd_valid)
    );

    assign last_rtn = rd_valid && ((rtn_q + COUNT_W'(1)) == count_q);
    assign sum_ok   = (rd_sum_q + rdata_ext) == checksum_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rdata_ext, RD_LAT[0]};
`endif

    // NOTE: every output and next_state gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        wen_ext    = 1'b0;
        ren_ext    = 1'b0;
        addr_ext   = BASE_ADDR;
        wdata_ext  = '0;
        case (state)
            ST_IDLE: begin
                if (start && !halt) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (halt) begin
                    next_state = ST_IDLE;
                end else if (handshake) begin
                    if (full) begin
                        next_state = ST_ERROR;
                    end else begin
                        wen_ext   = 1'b1;
                        addr_ext  = BASE_ADDR + (ADDR_W'(count_q) << 2);
                        wdata_ext = s_data;
                        if (s_last) next_state = AFTER_LAST;
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (issue_q < count_q) begin
                    ren_ext  = 1'b1;
                    addr_ext = BASE_ADDR + (ADDR_W'(issue_q) << 2);
                end
                if (last_rtn) next_state = sum_ok ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN: begin
                if (halt)       next_state = ST_IDLE;
                else if (start) next_state = ST_LOAD;
            end
            ST_ERROR: begin
                if (start && !halt) next_state = ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state    <= ST_IDLE;
            count_q  <= '0;
            error_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state    <= next_state;
            // enable rises one cycle after RUN entry and drops on the edge that leaves RUN
            enable_q <= (state == ST_RUN) && (next_state == ST_RUN);
            if (enter_load)   count_q <= '0;
            else if (wen_ext) count_q <= count_q + COUNT_W'(1);
            if (enter_load)                                          error_q <= 1'b0;
            else if (next_state == ST_ERROR && state != ST_ERROR) error_q <= 1'b1;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (!arst_n || enter_load) begin
            issue_q    <= '0;
            rtn_q      <= '0;
            checksum_q <= '0;
            rd_sum_q   <= '0;
        end else begin
            if (wen_ext) checksum_q <= checksum_q + s_data;
            if (ren_ext) issue_q    <= issue_q + COUNT_W'(1);
            if (rd_valid && state == ST_VERIFY) begin
                rtn_q    <= rtn_q + COUNT_W'(1);
                rd_sum_q <= rd_sum_q + rdata_ext;
            end
        end
    end
`endif

    assign cpu_enable = enable_q;
    assign word_count = count_q;
    assign load_error = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader; the VERIFY scenarios run when LOADER_VERIFY_EN is defined.
module tb_imem_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h0000_0000_0000_1000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        arst_n, start, halt, s_valid, s_ready, s_last;
    logic        wen_ext, ren_ext, cpu_enable, load_error;
    logic [31:0] s_data, wdata_ext, rdata_ext;
    logic [63:0] addr_ext;
    logic [9:0]  word_count;
    bit          corrupt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imem_program_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (start),
        .halt      (halt),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .addr_ext  (addr_ext),
        .wen_ext   (wen_ext),
        .ren_ext   (ren_ext),
        .wdata_ext (wdata_ext),
        .rdata_ext (rdata_ext),
        .cpu_enable(cpu_enable),
        .word_count(word_count),
        .load_error(load_error)
    );

    // Instruction memory with an RD_LAT-cycle read pipeline; can flip a bit of word 2 on read.
    logic [31:0] mem     [DEPTH];
    logic [31:0] rd_pipe [LAT];

    function automatic int unsigned word_idx(input logic [63:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    always @(posedge clk) begin
        if (wen_ext && word_idx(addr_ext) < DEPTH) mem[word_idx(addr_ext)] <= wdata_ext;
        if (ren_ext && word_idx(addr_ext) < DEPTH)
            rd_pipe[0] <= mem[word_idx(addr_ext)] ^ ((corrupt && word_idx(addr_ext) == 2) ? 32'h1 : 32'h0);
        else
            rd_pipe[0] <= 32'h0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rdata_ext = rd_pipe[LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b0; halt = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; corrupt = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        total++;
        if ({s_ready, wen_ext, ren_ext, cpu_enable, load_error} !== 5'b0)
            $display("FAIL reset_flags: got %b, expected 00000",
                     {s_ready, wen_ext, ren_ext, cpu_enable, load_error});
        else passed++;
        total++;
        if ({addr_ext, wdata_ext, word_count} !== {BASE, 32'h0, 10'd0})
            $display("FAIL reset_values: got addr=%h wdata=%h count=%0d, expected addr=%h wdata=0 count=0",
                     addr_ext, wdata_ext, word_count, BASE);
        else passed++;
        arst_n = 1'b1;
        next_cycle();
    endtask

    // Start a load of n words; gap 0 = random valid, otherwise valid every gap-th cycle.
    task automatic test_load(input string name, input int n, input int gap,
                             input bit fixed, input bit bad_read);
        logic [31:0] words[$];
        int          k, cyc;
        bit          v;
        for (int i = 0; i < n; i++) words.push_back(fixed ? 32'h13 + 32'(i) : $urandom);
        corrupt = bad_read;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            v = (gap == 0) ? bit'($urandom_range(1)) : ((cyc % gap) == 0);
            s_valid = v;
            s_data  = v ? words[k] : $urandom;
            s_last  = v && (k == n - 1);
            @(negedge clk);
            total++;
            if ({s_ready, wen_ext} !== {1'b1, v})
                $display("FAIL %s_cyc%0d_ready_wen: got %b, expected %b", name, cyc, {s_ready, wen_ext}, {1'b1, v});
            else passed++;
            if (v) begin
                total++;
                if ({addr_ext, wdata_ext} !== {BASE + 64'(4 * k), words[k]})
                    $display("FAIL %s_write%0d: got addr=%h data=%h, expected addr=%h data=%h",
                             name, k, addr_ext, wdata_ext, BASE + 64'(4 * k), words[k]);
                else passed++;
            end
            next_cycle();
            if (v) k++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        total++;
        if (k != n) $display("FAIL %s_stream_timeout: got %0d words, expected %0d", name, k, n);
        else passed++;
`ifdef LOADER_VERIFY_EN
        for (int i = 0; i < n + LAT; i++) begin
            @(negedge clk);
            total++;
            if ({ren_ext, wen_ext, cpu_enable, s_ready} !== {(i < n), 3'b000})
                $display("FAIL %s_verify%0d_ctl: got %b, expected %b",
                         name, i, {ren_ext, wen_ext, cpu_enable, s_ready}, {(i < n), 3'b000});
            else passed++;
            if (i < n) begin
                total++;
                if (addr_ext !== BASE + 64'(4 * i))
                    $display("FAIL %s_verify%0d_addr: got %h, expected %h", name, i, addr_ext, BASE + 64'(4 * i));
                else passed++;
            end
            next_cycle();
        end
        if (bad_read) begin
            repeat (2) begin
                @(negedge clk);
                total++;
                if ({load_error, cpu_enable, s_ready} !== 3'b100)
                    $display("FAIL %s_verify_error: got err/en/rdy=%b, expected 100",
                             name, {load_error, cpu_enable, s_ready});
                else passed++;
                next_cycle();
            end
            corrupt = 1'b0;
            return;
        end
`endif
        @(negedge clk);
        total++;
        if ({cpu_enable, load_error, s_ready, wen_ext, word_count} !== {4'b0000, 10'(n)})
            $display("FAIL %s_run_entry: got en/err/rdy/wen=%b count=%0d, expected 0000 count=%0d",
                     name, {cpu_enable, load_error, s_ready, wen_ext}, word_count, n);
        else passed++;
        next_cycle();
        @(negedge clk);
        total++;
        if ({cpu_enable, wen_ext, ren_ext} !== 3'b100)
            $display("FAIL %s_enable: got en/wen/ren=%b, expected 100", name, {cpu_enable, wen_ext, ren_ext});
        else passed++;
        next_cycle();
    endtask

    // Entered from RUN with cpu_enable high.
    task automatic test_halt();
        halt = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_enable !== 1'b1) $display("FAIL halt_same_cycle: got en=%b, expected 1", cpu_enable);
        else passed++;
        next_cycle();
        halt = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_enable, s_ready} !== 2'b00)
            $display("FAIL halt_next_cycle: got en/rdy=%b, expected 00", {cpu_enable, s_ready});
        else passed++;
        start = 1'b1;
        halt  = 1'b1;
        next_cycle();
        start = 1'b0;
        halt  = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_enable, s_ready} !== 2'b00)
            $display("FAIL start_halt_same: got en/rdy=%b, expected 00", {cpu_enable, s_ready});
        else passed++;
        next_cycle();
        test_load("preload", 2, 1, 1'b0, 1'b0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({cpu_enable, s_ready, load_error, word_count} !== {3'b010, 10'd0})
            $display("FAIL reload_from_run: got en/rdy/err=%b count=%0d, expected 010 count=0",
                     {cpu_enable, s_ready, load_error}, word_count);
        else passed++;
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
        @(negedge clk);
        total++;
        if ({s_ready, cpu_enable} !== 2'b00)
            $display("FAIL halt_in_load: got rdy/en=%b, expected 00", {s_ready, cpu_enable});
        else passed++;
        next_cycle();
    endtask

    // DEPTH+1 words without s_last: the extra word is refused and the loader parks in ERROR.
    task automatic test_overflow();
        logic [31:0] w;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            w = $urandom;
            s_valid = 1'b1;
            s_data  = w;
            s_last  = 1'b0;
            @(negedge clk);
            total++;
            if ({s_ready, wen_ext} !== {1'b1, (i < DEPTH)})
                $display("FAIL overflow_cyc%0d_ready_wen: got %b, expected %b", i, {s_ready, wen_ext}, {1'b1, (i < DEPTH)});
            else passed++;
            if (i < DEPTH) begin
                total++;
                if ({addr_ext, wdata_ext} !== {BASE + 64'(4 * i), w})
                    $display("FAIL overflow_write%0d: got addr=%h data=%h, expected addr=%h data=%h",
                             i, addr_ext, wdata_ext, BASE + 64'(4 * i), w);
                else passed++;
            end
            next_cycle();
        end
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({load_error, cpu_enable, s_ready, wen_ext, word_count} !== {4'b1000, 10'(DEPTH)})
            $display("FAIL overflow_error: got err/en/rdy/wen=%b count=%0d, expected 1000 count=%0d",
                     {load_error, cpu_enable, s_ready, wen_ext}, word_count, DEPTH);
        else passed++;
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
        @(negedge clk);
        total++;
        if ({load_error, s_ready} !== 2'b10)
            $display("FAIL error_ignores_halt: got err/rdy=%b, expected 10", {load_error, s_ready});
        else passed++;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({load_error, s_ready, word_count} !== {2'b01, 10'd0})
            $display("FAIL error_recover: got err/rdy=%b count=%0d, expected 01 count=0",
                     {load_error, s_ready}, word_count);
        else passed++;
        halt = 1'b1;
        next_cycle();
        halt = 1'b0;
    endtask

    // Reset applied after two accepted words while the stream is still offering data.
    task automatic test_mid_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        s_valid = 1'b1;
        repeat (2) begin
            s_data = $urandom;
            next_cycle();
        end
        arst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if ({s_ready, wen_ext, ren_ext, cpu_enable, load_error} !== 5'b0)
            $display("FAIL midreset_flags: got %b, expected 00000",
                     {s_ready, wen_ext, ren_ext, cpu_enable, load_error});
        else passed++;
        total++;
        if ({addr_ext, wdata_ext, word_count} !== {BASE, 32'h0, 10'd0})
            $display("FAIL midreset_values: got addr=%h wdata=%h count=%0d, expected addr=%h wdata=0 count=0",
                     addr_ext, wdata_ext, word_count, BASE);
        else passed++;
        arst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if ({s_ready, wen_ext} !== 2'b00)
            $display("FAIL midreset_idle: got rdy/wen=%b, expected 00", {s_ready, wen_ext});
        else passed++;
        s_valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load("basic", 4, 1, 1'b1, 1'b0);
        test_halt();
        test_load("gapped", 4, 3, 1'b0, 1'b0);
        test_overflow();
        test_mid_reset();
        for (int r = 0; r < 6; r++)
            test_load($sformatf("rand%0d", r), int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
`ifdef LOADER_VERIFY_EN
        test_load("verify_bad", 4, 1, 1'b0, 1'b1);
        test_load("verify_good", 3, 2, 1'b0, 1'b0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
